// File: rtl/vga_timing_gen_pkg.sv
// Purpose : shared timing description for the raster timing generator.
//           timing_t holds one complete horizontal/vertical timing set,
//           VGA_640x480 is the classic 800x525 mode, and hmax()/vmax()
//           return the total line length and frame height.
// Ports   : none (package).
package vga_timing_gen_pkg;

    typedef struct packed {
        int hactive;
        int hfp;
        int hsyn;
        int hbp;
        int vactive;
        int vfp;
        int vsyn;
        int vbp;
    } timing_t;

    localparam timing_t VGA_640x480 = '{
        hactive: 640, hfp: 16, hsyn: 96, hbp: 48,
        vactive: 480, vfp: 11, vsyn: 2,  vbp: 32
    };

    function automatic int hmax(input timing_t t);
        return t.hactive + t.hfp + t.hsyn + t.hbp;
    endfunction

    function automatic int vmax(input timing_t t);
        return t.vactive + t.vfp + t.vsyn + t.vbp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose : bundle of the timing generator's pixel-side signals.
// Ports   : master = the generator (takes pix_en, drives scan/sync outputs)
//           slave  = the consumer (drives pix_en, reads scan/sync outputs)
//   pix_en       pixel tick enable
//   x, y         scan position
//   active       visible area, aligned with x/y
//   hsync/vsync  syncs with polarity applied, delayed by the pipeline latency
//   blank_b      1 = visible pixel, delayed by the pipeline latency
//   line_start   strobe on the tick at x==0
//   frame_start  strobe on the tick at x==0,y==0
//   frame_cnt    completed-frame count
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int FW = 16
);
    logic          pix_en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          blank_b;
    logic          line_start;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;

    modport master (
        input  pix_en,
        output x, y, active, hsync, vsync, blank_b, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  x, y, active, hsync, vsync, blank_b, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Purpose : enable-gated shift register of DEPTH stages, each W bits wide,
//           asynchronously reset to RST_VAL. DEPTH=0 is a plain wire.
// Ports   : clk, reset (async, active-high), en_i (shift enable),
//           d_i (stage-0 input), q_o (last stage output)
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_s;
        assign unused_s = ^{clk, reset, en_i};
        assign q_o      = d_i;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];

        // Shift register: stage 0 takes the input, each later stage the one before it
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : parametrised raster timing generator. Scans x/y, counts frames,
//           decodes sync/visible regions and delays them PIPE_LAT pixel
//           ticks so they line up with pixel data of the same latency.
// Ports   : clk   pixel-domain clock
//           reset asynchronous, active-high
//           bus   vga_timing_gen_if.master (pix_en in; scan/sync/strobes out)
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int HACTIVE  = VGA_640x480.hactive,
    parameter int HFP      = VGA_640x480.hfp,
    parameter int HSYN     = VGA_640x480.hsyn,
    parameter int HBP      = VGA_640x480.hbp,
    parameter int VACTIVE  = VGA_640x480.vactive,
    parameter int VFP      = VGA_640x480.vfp,
    parameter int VSYN     = VGA_640x480.vsyn,
    parameter int VBP      = VGA_640x480.vbp,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE_LAT = 2,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int FW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    vga_timing_gen_if.master bus
);

    localparam timing_t TIM = '{
        hactive: HACTIVE, hfp: HFP, hsyn: HSYN, hbp: HBP,
        vactive: VACTIVE, vfp: VFP, vsyn: VSYN, vbp: VBP
    };
    localparam int          HMAX     = hmax(TIM);
    localparam int          VMAX     = vmax(TIM);
    localparam int unsigned HA_END   = HACTIVE;
    localparam int unsigned VA_END   = VACTIVE;
    localparam int unsigned HS_START = HACTIVE + HFP;
    localparam int unsigned HS_END   = HACTIVE + HFP + HSYN;
    localparam int unsigned VS_START = VACTIVE + VFP;
    localparam int unsigned VS_END   = VACTIVE + VFP + VSYN;
    localparam logic        HS_ACT   = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic        VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;

    if (XW < 1 || YW < 1 || FW < 1) begin : g_chk_w
        $error("vga_timing_gen: XW, YW and FW must be > 0");
    end
    if (HMAX > 2**XW) begin : g_chk_x
        $error("vga_timing_gen: XW too narrow for HMAX-1");
    end
    if (VMAX > 2**YW) begin : g_chk_y
        $error("vga_timing_gen: YW too narrow for VMAX-1");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_chk_lat
        $error("vga_timing_gen: PIPE_LAT must be 0..15");
    end

    logic [XW-1:0] x_q,  x_d;
    logic [YW-1:0] y_q,  y_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          hs_raw_s, vs_raw_s, vis_s;
    logic [2:0]    dly_s;
    logic          line_start_s;

    // Scan counter next state: x wraps at HMAX-1, y steps on x wrap, frame count on y wrap
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (bus.pix_en) begin
            if (x_q == XW'(HMAX - 1)) begin
                x_d = '0;
                if (y_q == YW'(VMAX - 1)) begin
                    y_d  = '0;
                    fc_d = fc_q + FW'(1'b1);
                end else begin
                    y_d = y_q + YW'(1'b1);
                end
            end else begin
                x_d = x_q + XW'(1'b1);
            end
        end else begin
            x_d = x_q;
        end
    end

    // Scan counter and frame counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            fc_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    // Undelayed region decode; compared at 32 bits so HMAX==2**XW cannot wrap the bounds
    assign hs_raw_s = (32'(x_q) >= HS_START) && (32'(x_q) < HS_END);
    assign vs_raw_s = (32'(y_q) >= VS_START) && (32'(y_q) < VS_END);
    assign vis_s    = (32'(x_q) < HA_END) && (32'(y_q) < VA_END);

    vga_delay_line #(
        .W       (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (3'b000)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en_i  (bus.pix_en),
        .d_i   ({hs_raw_s, vs_raw_s, vis_s}),
        .q_o   (dly_s)
    );

    // Raw syncs are 0 at x=y=0, so only blank needs forcing while in reset with no delay stages
    if (PIPE_LAT == 0) begin : g_blank_comb
        assign bus.blank_b = dly_s[0] & ~reset;
    end else begin : g_blank_reg
        assign bus.blank_b = dly_s[0];
    end

    assign bus.hsync  = dly_s[2] ^ ~HS_ACT;
    assign bus.vsync  = dly_s[1] ^ ~VS_ACT;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.active = vis_s;
    assign bus.frame_cnt = fc_q;

    assign line_start_s    = bus.pix_en && (x_q == '0) && !reset;
    assign bus.line_start  = line_start_s;
    assign bus.frame_start = line_start_s && (y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 16x8 timing in three flavours (no delay, 2-tick
// delay, 1-tick delay with positive syncs) plus the default 800x525 mode.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(4),  .YW(3),  .FW(8))  b0 ();
    vga_timing_gen_if #(.XW(4),  .YW(3),  .FW(8))  b2 ();
    vga_timing_gen_if #(.XW(4),  .YW(3),  .FW(8))  bp ();
    vga_timing_gen_if #(.XW(10), .YW(10), .FW(16)) bd ();

    vga_timing_gen #(.HACTIVE(8), .HFP(2), .HSYN(3), .HBP(3), .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1),
                     .HS_POL(0), .VS_POL(0), .PIPE_LAT(0), .XW(4), .YW(3), .FW(8))
        u_d0 (.clk(clk), .reset(reset), .bus(b0));
    vga_timing_gen #(.HACTIVE(8), .HFP(2), .HSYN(3), .HBP(3), .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1),
                     .HS_POL(0), .VS_POL(0), .PIPE_LAT(2), .XW(4), .YW(3), .FW(8))
        u_d2 (.clk(clk), .reset(reset), .bus(b2));
    vga_timing_gen #(.HACTIVE(8), .HFP(2), .HSYN(3), .HBP(3), .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1),
                     .HS_POL(1), .VS_POL(1), .PIPE_LAT(1), .XW(4), .YW(3), .FW(8))
        u_dp (.clk(clk), .reset(reset), .bus(bp));
    vga_timing_gen u_dd (.clk(clk), .reset(reset), .bus(bd));

    // Reference decode for the small timing (HMAX=16, VMAX=8)
    function automatic logic m_hs(input int x);
        return (x >= 10 && x < 13);
    endfunction
    function automatic logic m_vs(input int y);
        return (y >= 5 && y < 7);
    endfunction
    function automatic logic m_vis(input int x, input int y);
        return (x < 8 && y < 4);
    endfunction

    task automatic set_pe(input logic v);
        b0.pix_en = v;
        b2.pix_en = v;
        bp.pix_en = v;
        bd.pix_en = v;
    endtask

    // Leaves every DUT at tick 0 with pix_en=1, sampled 1 time unit after a falling edge
    task automatic apply_reset();
        reset = 1'b1;
        set_pe(1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_pe(1'b1);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({b0.x, b0.y, b0.frame_cnt, b0.hsync, b0.vsync, b0.blank_b, b0.line_start, b0.frame_start}
            !== {4'd0, 3'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_lat0: got x=%0d y=%0d fc=%0d hs=%b vs=%b bl=%b ls=%b fs=%b want 0 0 0 1 1 0 0 0",
                     b0.x, b0.y, b0.frame_cnt, b0.hsync, b0.vsync, b0.blank_b, b0.line_start, b0.frame_start);
        end
        n_checks++;
        if ({b2.hsync, b2.vsync, b2.blank_b} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_lat2: got hs/vs/bl=%b%b%b want 110", b2.hsync, b2.vsync, b2.blank_b);
        end
        n_checks++;
        if ({bp.hsync, bp.vsync, bp.blank_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pospol: got hs/vs/bl=%b%b%b want 000", bp.hsync, bp.vsync, bp.blank_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_small_timing();
        logic [12:0] exp0;
        logic [10:0] exp2;
        logic        e_hs, e_vs, e_bl;
        int          bl_cnt = 0;
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            int px, py, qx, qy;
            px = n % 16;
            py = (n / 16) % 8;
            exp0 = {4'(px), 3'(py), ~m_hs(px), ~m_vs(py), m_vis(px, py), m_vis(px, py),
                    px == 0, (px == 0) && (py == 0)};
            n_checks++;
            if ({b0.x, b0.y, b0.hsync, b0.vsync, b0.blank_b, b0.active, b0.line_start, b0.frame_start} !== exp0) begin
                n_fail++;
                $display("FAIL lat0_tick%0d: got %h want %h", n,
                         {b0.x, b0.y, b0.hsync, b0.vsync, b0.blank_b, b0.active, b0.line_start, b0.frame_start}, exp0);
            end
            if (n >= 2) begin
                qx = (n - 2) % 16;
                qy = ((n - 2) / 16) % 8;
                e_hs = ~m_hs(qx);
                e_vs = ~m_vs(qy);
                e_bl = m_vis(qx, qy);
            end else begin
                e_hs = 1'b1;
                e_vs = 1'b1;
                e_bl = 1'b0;
            end
            exp2 = {4'(px), 3'(py), e_hs, e_vs, e_bl, m_vis(px, py)};
            n_checks++;
            if ({b2.x, b2.y, b2.hsync, b2.vsync, b2.blank_b, b2.active} !== exp2) begin
                n_fail++;
                $display("FAIL lat2_tick%0d: got %h want %h", n,
                         {b2.x, b2.y, b2.hsync, b2.vsync, b2.blank_b, b2.active}, exp2);
            end
            if (n >= 128 && b2.blank_b === 1'b1) bl_cnt++;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (bl_cnt !== 32) begin
            n_fail++;
            $display("FAIL lat2_blank_count: got %0d want 32", bl_cnt);
        end
    endtask

    task automatic test_polarity();
        logic [2:0] e;
        apply_reset();
        for (int n = 0; n < 128; n++) begin
            int qx, qy;
            if (n >= 1) begin
                qx = (n - 1) % 16;
                qy = ((n - 1) / 16) % 8;
                e  = {m_hs(qx), m_vs(qy), m_vis(qx, qy)};
            end else begin
                e = 3'b000;
            end
            n_checks++;
            if ({bp.hsync, bp.vsync, bp.blank_b} !== e) begin
                n_fail++;
                $display("FAIL pospol_tick%0d: got %b%b%b want %b", n, bp.hsync, bp.vsync, bp.blank_b, e);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_frame_count();
        int fs_seen = 0;
        apply_reset();
        for (int n = 0; n <= 384; n++) begin
            if (b0.frame_start === 1'b1) fs_seen++;
            if (n == 127 || n == 128) begin
                n_checks++;
                if (b0.frame_cnt !== 8'(n / 128)) begin
                    n_fail++;
                    $display("FAIL frame_cnt_tick%0d: got %0d want %0d", n, b0.frame_cnt, n / 128);
                end
            end
            if (n < 384) begin
                @(negedge clk);
                #1;
            end
        end
        n_checks++;
        if (b0.frame_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL frame_cnt_3frames: got %0d want 3", b0.frame_cnt);
        end
        n_checks++;
        if (fs_seen !== 4) begin
            n_fail++;
            $display("FAIL frame_start_count: got %0d want 4", fs_seen);
        end
    endtask

    task automatic test_pix_en();
        int fs_seen = 0;
        reset = 1'b1;
        set_pe(1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 384; k++) begin
            int   ticks, px, py;
            logic pe;
            pe = ((k % 3) == 0);
            b0.pix_en = pe;
            #1;
            ticks = (k + 2) / 3;
            px = ticks % 16;
            py = (ticks / 16) % 8;
            n_checks++;
            if ({b0.x, b0.y, b0.line_start, b0.frame_start}
                !== {4'(px), 3'(py), pe && (px == 0), pe && (px == 0) && (py == 0)}) begin
                n_fail++;
                $display("FAIL pixen_clk%0d: got x=%0d y=%0d ls=%b fs=%b want x=%0d y=%0d pe=%b",
                         k, b0.x, b0.y, b0.line_start, b0.frame_start, px, py, pe);
            end
            if (b0.frame_start === 1'b1) fs_seen++;
            if (k < 384) @(negedge clk);
        end
        n_checks++;
        if ({fs_seen, b0.frame_cnt} !== {32'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL pixen_frame_period: got fs=%0d fc=%0d want fs=2 fc=1", fs_seen, b0.frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        repeat (38) @(negedge clk);
        #1;
        n_checks++;
        if ({b0.x, b0.y, b0.blank_b, b2.blank_b} !== {4'd6, 3'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL midframe_pos: got x=%0d y=%0d bl0=%b bl2=%b want 6 2 1 1", b0.x, b0.y, b0.blank_b, b2.blank_b);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({b0.x, b0.y, b0.frame_cnt, b0.blank_b, b0.line_start, b2.hsync, b2.vsync, b2.blank_b, bp.hsync, bp.vsync}
            !== {4'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midframe_async_reset: got x=%0d y=%0d fc=%0d bl0=%b ls=%b hs2=%b vs2=%b bl2=%b hsp=%b vsp=%b",
                     b0.x, b0.y, b0.frame_cnt, b0.blank_b, b0.line_start, b2.hsync, b2.vsync, b2.blank_b, bp.hsync, bp.vsync);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({b0.frame_start, b2.frame_start, b2.blank_b} !== 3'b110) begin
            n_fail++;
            $display("FAIL release_tick0: got fs0=%b fs2=%b bl2=%b want 110", b0.frame_start, b2.frame_start, b2.blank_b);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (b2.blank_b !== 1'b0) begin
            n_fail++;
            $display("FAIL release_tick1_blank: got %b want 0", b2.blank_b);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (b2.blank_b !== 1'b1) begin
            n_fail++;
            $display("FAIL release_tick2_blank: got %b want 1", b2.blank_b);
        end
    endtask

    task automatic test_default_lines();
        int hs_low = 0, vs_low = 0, bl_hi = 0;
        apply_reset();
        for (int n = 0; n < 1602; n++) begin
            if (bd.hsync === 1'b0)  hs_low++;
            if (bd.vsync === 1'b0)  vs_low++;
            if (bd.blank_b === 1'b1) bl_hi++;
            if (n == 799) begin
                n_checks++;
                if ({bd.x, bd.y} !== {10'd799, 10'd0}) begin
                    n_fail++;
                    $display("FAIL default_x_last: got x=%0d y=%0d want 799 0", bd.x, bd.y);
                end
            end
            if (n == 800) begin
                n_checks++;
                if ({bd.x, bd.y, bd.line_start, bd.frame_start} !== {10'd0, 10'd1, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL default_line_wrap: got x=%0d y=%0d ls=%b fs=%b want 0 1 1 0",
                             bd.x, bd.y, bd.line_start, bd.frame_start);
                end
            end
            @(negedge clk);
            #1;
        end
        n_checks++;
        if ({hs_low, vs_low, bl_hi} !== {32'd192, 32'd0, 32'd1280}) begin
            n_fail++;
            $display("FAIL default_two_lines: got hs_low=%0d vs_low=%0d blank_hi=%0d want 192 0 1280", hs_low, vs_low, bl_hi);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_pe(1'b0);
        test_reset();
        test_small_timing();
        test_polarity();
        test_frame_count();
        test_pix_en();
        test_reset_midframe();
        test_default_lines();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
